// File: rtl/leds_pwm_pkg.sv
// Shared constants for the PWM LED controller: register offsets, CTRL bits, PWM width.
// Latency: n/a (package only).
// Backpressure: n/a.
package leds_pwm_pkg;
   localparam int PWM_W = 8;

   // Byte offsets of the registers inside the 16-byte window
   localparam logic [3:0] OFF_CTRL  = 4'h0;
   localparam logic [3:0] OFF_PRESC = 4'h4;
   localparam logic [3:0] OFF_DUTY0 = 4'h8;
   localparam logic [3:0] OFF_DUTY1 = 4'hC;

   // CTRL bit positions
   localparam int CTRL_EN    = 0;
   localparam int CTRL_BLINK = 1;

   // Channel is lit while the counter is below duty; full scale means always lit
   function automatic logic pwm_on(input logic [PWM_W-1:0] duty, input logic [PWM_W-1:0] cnt);
      return (duty == {PWM_W{1'b1}}) || (cnt < duty);
   endfunction
endpackage

// File: rtl/leds_pwm_channel.sv
// One PWM channel: compares its duty against the shared PWM counter.
// Latency: combinational, the output register lives in the top.
// Backpressure: none.
module leds_pwm_channel
   import leds_pwm_pkg::*;
(
   input  logic [PWM_W-1:0] i_duty,
   input  logic [PWM_W-1:0] i_pwm_cnt,
   output logic             o_chan_on
);
   assign o_chan_on = pwm_on(i_duty, i_pwm_cnt);
endmodule

// File: rtl/leds_pwm_bus_interface.sv
// Memory-mapped PWM LED controller with global prescaler and blink mode.
// Latency: reads combinational, writes land on the request edge, leds registered one cycle.
// Backpressure: none; fc_bus signals completion (reads same cycle, writes one cycle later).
module leds_pwm_bus_interface
   import leds_pwm_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0,
   parameter int          LED_COUNT = 4,
   parameter int          PRESC_W   = 16
)(
   input  logic                 clk,
   input  logic                 rst,
   output logic [LED_COUNT-1:0] leds,
   input  logic [31:0]          addr_bus,
   inout  wire logic [31:0]     data_bus,
   input  logic                 rd_bus,
   input  logic                 wr_bus,
   input  logic [3:0]           data_mask_bus,
   output wire logic            fc_bus
);
   logic                 r_en, r_blink_en, r_written, r_phase;
   logic [PRESC_W-1:0]   r_presc, r_pcnt, w_presc_bmask;
   logic [7:0]           r_blink_per, r_bcnt;
   logic [PWM_W-1:0]     r_pwm_cnt;
   logic [LED_COUNT-1:0] w_chan_on;
   logic [63:0]          w_duty_words;
   logic [31:0]          w_rdata;
   logic [3:0]           w_off;
   logic                 w_hit, w_req, w_rd_req, w_wr_req, w_tick, w_period_end;

   // Only word-aligned addresses inside the window decode; rd and wr together is no request
   assign w_off    = addr_bus[3:0];
   assign w_hit    = (addr_bus[31:4] == BASE_ADDR[31:4]) && (addr_bus[1:0] == 2'b00);
   assign w_req    = w_hit && (rd_bus ^ wr_bus);
   assign w_rd_req = w_req && rd_bus;
   assign w_wr_req = w_req && wr_bus;

   assign data_bus = w_rd_req ? w_rdata : 32'bz;
   assign fc_bus   = w_req ? (w_rd_req | r_written) : 1'bz;

   // Per-bit write enables for the prescaler field from the byte lanes
   for (genvar b = 0; b < PRESC_W; b++) begin : g_presc_mask
      assign w_presc_bmask[b] = data_mask_bus[b/8];
   end

   // Duty registers and comparators; absent channels read back as zero
   for (genvar i = 0; i < 8; i++) begin : g_lane
      if (i < LED_COUNT) begin : g_ch
         logic [PWM_W-1:0] r_duty;
         logic             w_we;
         assign w_we = w_wr_req && data_mask_bus[i%4] &&
                       (w_off == ((i < 4) ? OFF_DUTY0 : OFF_DUTY1));
         // Duty byte update; takes effect at the next compare
         always_ff @(posedge clk) begin
            if (rst)       r_duty <= '0;
            else if (w_we) r_duty <= data_bus[(i%4)*8 +: 8];
         end
         leds_pwm_channel u_chan (
            .i_duty    (r_duty),
            .i_pwm_cnt (r_pwm_cnt),
            .o_chan_on (w_chan_on[i])
         );
         assign w_duty_words[i*8 +: 8] = r_duty;
      end else begin : g_none
         assign w_duty_words[i*8 +: 8] = 8'h00;
      end
   end

   // Read data mux
   always_comb begin
      w_rdata = '0;
      case (w_off)
         OFF_CTRL: begin
            w_rdata[CTRL_EN]    = r_en;
            w_rdata[CTRL_BLINK] = r_blink_en;
         end
         OFF_PRESC: begin
            w_rdata[PRESC_W-1:0] = r_presc;
            w_rdata[31:24]       = r_blink_per;
         end
         OFF_DUTY0: w_rdata = w_duty_words[31:0];
         OFF_DUTY1: w_rdata = w_duty_words[63:32];
         default:   ;
      endcase
   end

   // CTRL/PRESC register writes and the write-completion flag
   always_ff @(posedge clk) begin
      if (rst) begin
         r_en        <= 1'b0;
         r_blink_en  <= 1'b0;
         r_presc     <= '0;
         r_blink_per <= '0;
         r_written   <= 1'b0;
      end else begin
         r_written <= w_wr_req;
         if (w_wr_req && (w_off == OFF_CTRL) && data_mask_bus[0]) begin
            r_en       <= data_bus[CTRL_EN];
            r_blink_en <= data_bus[CTRL_BLINK];
         end
         if (w_wr_req && (w_off == OFF_PRESC)) begin
            r_presc <= (r_presc & ~w_presc_bmask) | (data_bus[PRESC_W-1:0] & w_presc_bmask);
            if (data_mask_bus[3]) r_blink_per <= data_bus[31:24];
         end
      end
   end

   assign w_tick       = r_en && (r_pcnt == r_presc);
   assign w_period_end = w_tick && (r_pwm_cnt == {PWM_W{1'b1}});

   // Prescaler, PWM and blink counters; all held at start while disabled
   always_ff @(posedge clk) begin
      if (rst || !r_en) begin
         r_pcnt    <= '0;
         r_pwm_cnt <= '0;
         r_bcnt    <= '0;
         r_phase   <= 1'b1;
      end else begin
         // >= also restarts cleanly when PRESC shrinks below the running count
         r_pcnt <= (r_pcnt >= r_presc) ? '0 : r_pcnt + PRESC_W'(1);
         if (w_tick) r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
         if (!r_blink_en) begin
            r_bcnt  <= '0;
            r_phase <= 1'b1;
         end else if (w_period_end) begin
            if (r_bcnt == r_blink_per) begin
               r_bcnt  <= '0;
               r_phase <= ~r_phase;
            end else begin
               r_bcnt <= r_bcnt + 8'd1;
            end
         end
      end
   end

   // Registered LED drive
   always_ff @(posedge clk) begin
      if (rst) leds <= '0;
      else     leds <= (r_en && r_phase) ? w_chan_on : '0;
   end
endmodule

// File: tb/tb_leds_pwm_bus_interface.sv
// Bench for the PWM LED controller: directed bus checks plus randomized PWM/blink runs.
// Expected LED waveforms come from closed-form arithmetic on cycles since enable.
// Bus handshake is driven directly; no backpressure beyond fc_bus observation.
module tb_leds_pwm_bus_interface;
   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  leds;
   logic [31:0] addr_bus;
   wire  [31:0] data_bus;
   logic        rd_bus, wr_bus;
   logic [3:0]  data_mask_bus;
   wire         fc_bus;

   logic [31:0] tb_dat;
   logic        tb_drv;
   assign data_bus = tb_drv ? tb_dat : 32'bz;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference register contents
   logic        m_en, m_blink;
   logic [15:0] m_presc;
   logic [7:0]  m_bper;
   logic [7:0]  m_duty [4];

   logic [3:0]  hist [5000];

   leds_pwm_bus_interface #(.BASE_ADDR(32'h0), .LED_COUNT(4), .PRESC_W(16)) dut (
      .clk           (clk),
      .rst           (rst),
      .leds          (leds),
      .addr_bus      (addr_bus),
      .data_bus      (data_bus),
      .rd_bus        (rd_bus),
      .wr_bus        (wr_bus),
      .data_mask_bus (data_mask_bus),
      .fc_bus        (fc_bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_read(input logic [3:0] off);
      case (off)
         4'h0:    return {30'b0, m_blink, m_en};
         4'h4:    return {m_bper, 8'h00, m_presc};
         4'h8:    return {m_duty[3], m_duty[2], m_duty[1], m_duty[0]};
         default: return 32'h0;
      endcase
   endfunction

   task automatic model_write(input logic [3:0] off, input logic [31:0] d, input logic [3:0] m);
      case (off)
         4'h0: if (m[0]) begin m_en = d[0]; m_blink = d[1]; end
         4'h4: begin
            if (m[0]) m_presc[7:0]  = d[7:0];
            if (m[1]) m_presc[15:8] = d[15:8];
            if (m[3]) m_bper        = d[31:24];
         end
         4'h8: for (int k = 0; k < 4; k++) if (m[k]) m_duty[k] = d[k*8 +: 8];
         default: ;
      endcase
   endtask

   // LED state j cycles after the enable takes hold, from the period/duty arithmetic
   function automatic logic [3:0] exp_leds(input int j);
      int per, pwm, period;
      logic ph;
      logic [3:0] r;
      per    = int'(m_presc) + 1;
      pwm    = (j / per) % 256;
      period = j / (256 * per);
      ph     = !m_blink || (((period / (int'(m_bper) + 1)) % 2) == 0);
      for (int i = 0; i < 4; i++)
         r[i] = m_en && ph && ((m_duty[i] == 8'hFF) || (pwm < int'(m_duty[i])));
      return r;
   endfunction

   function automatic int count_hi(input int ch, input int from, input int to);
      int c = 0;
      for (int j = from; j < to; j++) c += int'(hist[j][ch]);
      return c;
   endfunction

   task automatic bus_write(input logic [3:0] off, input logic [31:0] d, input logic [3:0] m);
      @(negedge clk);
      addr_bus = {28'h0, off}; tb_dat = d; tb_drv = 1'b1; data_mask_bus = m; wr_bus = 1'b1;
      #1 check("wr_fc_first", {31'b0, fc_bus}, 32'h0);
      @(posedge clk);
      @(negedge clk);
      wr_bus = 1'b0; tb_drv = 1'b0;
      model_write(off, d, m);
   endtask

   task automatic bus_read(input logic [3:0] off, input string tag);
      @(negedge clk);
      addr_bus = {28'h0, off}; rd_bus = 1'b1;
      #1;
      check({tag, "_data"}, data_bus, model_read(off));
      check({tag, "_fc"}, {31'b0, fc_bus}, 32'h1);
      rd_bus = 1'b0;
   endtask

   task automatic scenario(input logic [15:0] p, input logic [7:0] b, input logic bl,
                           input logic [31:0] duty, input int ncyc, input string tag);
      bus_write(4'h0, 32'h0, 4'hF);
      bus_write(4'h4, {b, 8'h00, p}, 4'hF);
      bus_write(4'h8, duty, 4'hF);
      bus_write(4'h0, {30'b0, bl, 1'b1}, 4'hF);
      for (int j = 0; j < ncyc; j++) begin
         @(negedge clk);
         hist[j] = leds;
         check(tag, {28'b0, leds}, {28'b0, exp_leds(j)});
      end
   endtask

   initial begin
      rst = 1'b1; rd_bus = 1'b0; wr_bus = 1'b0; addr_bus = '0; tb_dat = '0; tb_drv = 1'b0;
      data_mask_bus = '0;
      m_en = 1'b0; m_blink = 1'b0; m_presc = '0; m_bper = '0;
      for (int k = 0; k < 4; k++) m_duty[k] = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b0;

      // Reset state
      check("reset_leds", {28'b0, leds}, 32'h0);
      bus_read(4'h0, "reset_ctrl");
      bus_read(4'h4, "reset_presc");
      bus_read(4'h8, "reset_duty0");

      // Masked write held two cycles: fc low then high, only lane 1 lands
      @(negedge clk);
      addr_bus = 32'h8; tb_dat = 32'hAABBCCDD; tb_drv = 1'b1; data_mask_bus = 4'b0010;
      wr_bus = 1'b1;
      #1 check("mask_fc_first", {31'b0, fc_bus}, 32'h0);
      @(posedge clk);
      @(negedge clk);
      check("mask_fc_held", {31'b0, fc_bus}, 32'h1);
      wr_bus = 1'b0; tb_drv = 1'b0;
      model_write(4'h8, 32'hAABBCCDD, 4'b0010);
      bus_read(4'h8, "mask_readback");
      check("mask_value", model_read(4'h8), 32'h0000CC00);

      // rd and wr together: not a request, no write may land
      @(negedge clk);
      addr_bus = 32'h8; tb_dat = 32'hFFFFFFFF; tb_drv = 1'b1; data_mask_bus = 4'hF;
      rd_bus = 1'b1; wr_bus = 1'b1;
      #1 check("rdwr_fc_released", {31'b0, fc_bus === 1'b1}, 32'h0);
      @(posedge clk);
      @(negedge clk);
      check("rdwr_fc_released2", {31'b0, fc_bus === 1'b1}, 32'h0);
      rd_bus = 1'b0; wr_bus = 1'b0; tb_drv = 1'b0;
      bus_read(4'h8, "rdwr_nochange");

      // Misaligned write at +0x2 must not hit CTRL
      @(negedge clk);
      addr_bus = 32'h2; tb_dat = 32'h3; tb_drv = 1'b1; data_mask_bus = 4'hF; wr_bus = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("misal_wr_fc_released", {31'b0, fc_bus === 1'b1}, 32'h0);
      wr_bus = 1'b0; tb_drv = 1'b0;
      bus_read(4'h0, "misal_ctrl_nochange");

      // Misaligned read at +0xA must leave the bus released
      @(negedge clk);
      addr_bus = 32'hA; rd_bus = 1'b1;
      #1;
      check("misal_rd_fc_released", {31'b0, fc_bus === 1'b1}, 32'h0);
      check("misal_rd_data_released", {31'b0, data_bus === 32'h0000CC00}, 32'h0);
      rd_bus = 1'b0;

      // Free-running PWM, PRESC=0
      scenario(16'd0, 8'd0, 1'b0, 32'h00FF8000, 256, "pwm_p0");
      check("pwm_p0_ch0_cnt", count_hi(0, 0, 256), 0);
      check("pwm_p0_ch1_cnt", count_hi(1, 0, 256), 128);
      check("pwm_p0_ch2_cnt", count_hi(2, 0, 256), 256);
      check("pwm_p0_ch3_cnt", count_hi(3, 0, 256), 0);

      // Disable: leds drop one edge after en clears
      bus_write(4'h0, 32'h0, 4'hF);
      @(negedge clk);
      check("disable_leds", {28'b0, leds}, 32'h0);
      bus_read(4'h0, "disable_ctrl");

      // Prescaled PWM
      scenario(16'd3, 8'd0, 1'b0, 32'h00000040, 1024, "pwm_p3");
      check("pwm_p3_ch0_cnt", count_hi(0, 0, 1024), 256);

      // Blink with blink_per=1
      scenario(16'd0, 8'd1, 1'b1, 32'hFFFFFFFF, 2048, "blink");
      check("blink_on0", count_hi(0, 0, 512), 512);
      check("blink_off0", count_hi(0, 512, 1024), 0);
      check("blink_on1", count_hi(0, 1024, 1536), 512);
      check("blink_off1", count_hi(0, 1536, 2048), 0);
      bus_read(4'h4, "blink_presc_rb");

      // Randomized configurations
      for (int s = 0; s < 4; s++) begin
         logic [15:0] p;
         logic [7:0]  b;
         logic        bl;
         logic [31:0] d;
         p  = 16'($urandom_range(0, 2));
         b  = 8'($urandom_range(0, 2));
         bl = 1'($urandom_range(0, 1));
         for (int k = 0; k < 4; k++) begin
            case ($urandom_range(0, 3))
               0:       d[k*8 +: 8] = 8'h00;
               1:       d[k*8 +: 8] = 8'hFF;
               default: d[k*8 +: 8] = 8'($urandom);
            endcase
         end
         scenario(p, b, bl, d, 2 * 256 * (int'(p) + 1) * (int'(b) + 1) + 64, "rand");
         bus_read(4'h8, "rand_duty_rb");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
